// File: rtl/fwd_pkg.sv
// Shared helpers for the operand-forwarding unit: select-vector sizing and youngest-producer priority.
// Pure combinational functions; no latency, no backpressure.
package fwd_pkg;

    // Upper bound on producer stages the priority encoder is built for.
    localparam int MAX_STG = 8;

    // Widest select vector: one bit per producer stage plus the regfile bit.
    typedef logic [MAX_STG:0] fwd_sel_t;

    function automatic int sel_w(input int nstg);
        return nstg + 1;
    endfunction

    // Index of the regfile bit inside a select vector for an nstg-stage pipe.
    function automatic int sel_rf(input int nstg);
        return nstg;
    endfunction

    // Lowest set hit index below nstg (youngest producer); regfile index when none hit.
    function automatic int prio_idx(input logic [MAX_STG-1:0] hit, input int nstg);
        int idx;
        idx = sel_rf(nstg);
        for (int k = MAX_STG - 1; k >= 0; k--) begin
            if ((k < nstg) && hit[k]) begin
                idx = k;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/fwd_src_cmp.sv
// Per-source producer compare: hit vector, one-hot youngest-producer select, not-ready hazard flag.
// Combinational, 0 cycles; no backpressure (evaluated every cycle).
module fwd_src_cmp
    import fwd_pkg::*;
#(
    parameter int NSTG   = 3,
    parameter int AW     = 5,
    parameter int SUP_B0 = 1
) (
    input  logic [AW-1:0]      src_adr,
    input  logic               src_vld,
    input  logic [NSTG*AW-1:0] stg_rd_adr,
    input  logic [NSTG-1:0]    stg_wbk,
    input  logic [NSTG-1:0]    stg_rdy,
    input  logic [NSTG-1:0]    stg_stall,
    input  logic               b0_guard,
    output logic [NSTG:0]      sel,
    output logic               haz
);

    logic [MAX_STG-1:0] hit_pad;
    int                 win;

    always_comb begin
        hit_pad = '0;
        for (int k = 0; k < NSTG; k++) begin
            hit_pad[k] = src_vld & stg_wbk[k] & ~stg_stall[k]
                       & (stg_rd_adr[k*AW +: AW] != '0)
                       & (src_adr == stg_rd_adr[k*AW +: AW]);
        end
        // The stage-0 entry is the bubble inserted by our own stall last cycle.
        if ((SUP_B0 != 0) && b0_guard) begin
            hit_pad[0] = 1'b0;
        end
        win = prio_idx(hit_pad, NSTG);
        sel = (NSTG+1)'(1) << win;
        haz = |(sel[NSTG-1:0] & ~stg_rdy);
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// ID-stage forwarding/hazard unit: registered one-hot bypass selects, load-use stall, stall counter.
// Latency: sel_ex/stall_ld_ex 1 cycle, stall_ld combinational; never backpressured, stall only freezes keep.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int NSRC   = 2,
    parameter int NSTG   = 3,
    parameter int AW     = 5,
    parameter int CNT_W  = 16,
    parameter int SUP_B0 = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NSRC*AW-1:0]            src_adr,
    input  logic [NSRC-1:0]               src_vld,
    input  logic [NSTG*AW-1:0]            stg_rd_adr,
    input  logic [NSTG-1:0]               stg_wbk,
    input  logic [NSTG-1:0]               stg_rdy,
    input  logic [NSTG-1:0]               stg_stall,
    input  logic                          stall,
    input  logic                          stall_dly,
    input  logic                          rst_pipe,
    input  logic                          cnt_clr,
    output logic [NSRC*sel_w(NSTG)-1:0]   sel_ex,
    output logic                          stall_ld,
    output logic                          stall_ld_ex,
    output logic [CNT_W-1:0]              stall_cnt
);

    localparam int SW = sel_w(NSTG);

    logic [NSRC*SW-1:0] sel_nxt;
    logic [NSRC-1:0]    haz;
    logic               stall_pre;
    logic               keep;

    for (genvar s = 0; s < NSRC; s++) begin : g_src
        fwd_src_cmp #(
            .NSTG   (NSTG),
            .AW     (AW),
            .SUP_B0 (SUP_B0)
        ) u_cmp (
            .src_adr    (src_adr[s*AW +: AW]),
            .src_vld    (src_vld[s]),
            .stg_rd_adr (stg_rd_adr),
            .stg_wbk    (stg_wbk),
            .stg_rdy    (stg_rdy),
            .stg_stall  (stg_stall),
            .b0_guard   (stall_ld_ex),
            .sel        (sel_nxt[s*SW +: SW]),
            .haz        (haz[s])
        );
    end

    assign stall_pre = |haz;
    // While the pipe replays a stalled cycle, repeat the decision made before the stall.
    assign stall_ld  = stall_dly ? keep : stall_pre;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_ex      <= '0;
            stall_ld_ex <= 1'b0;
            keep        <= 1'b0;
        end else if (rst_pipe) begin
            sel_ex      <= '0;
            stall_ld_ex <= 1'b0;
            keep        <= 1'b0;
        end else begin
            sel_ex      <= sel_nxt;
            stall_ld_ex <= stall_ld;
            if (!stall) begin
                keep <= stall_ld;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
        end else if (stall_ld && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: stimulus queues hand-computed expectations per cycle,
// a negedge monitor pops and compares them against the outputs.
module tb_fwd_hazard_unit;

    localparam int NSRC = 2;
    localparam int NSTG = 3;
    localparam int AW   = 5;
    localparam int CW   = 16;

    localparam logic [3:0] W_SL   = 4'b0001;
    localparam logic [3:0] W_SEL  = 4'b0010;
    localparam logic [3:0] W_SLEX = 4'b0100;
    localparam logic [3:0] W_CNT  = 4'b1000;

    logic              clk;
    logic              rst;
    logic [NSRC*AW-1:0] src_adr;
    logic [NSRC-1:0]   src_vld;
    logic [NSTG*AW-1:0] stg_rd_adr;
    logic [NSTG-1:0]   stg_wbk;
    logic [NSTG-1:0]   stg_rdy;
    logic [NSTG-1:0]   stg_stall;
    logic              stall;
    logic              stall_dly;
    logic              rst_pipe;
    logic              cnt_clr;
    logic [7:0]        sel_ex;
    logic              stall_ld;
    logic              stall_ld_ex;
    logic [CW-1:0]     stall_cnt;

    fwd_hazard_unit #(
        .NSRC(NSRC), .NSTG(NSTG), .AW(AW), .CNT_W(CW), .SUP_B0(1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .src_adr     (src_adr),
        .src_vld     (src_vld),
        .stg_rd_adr  (stg_rd_adr),
        .stg_wbk     (stg_wbk),
        .stg_rdy     (stg_rdy),
        .stg_stall   (stg_stall),
        .stall       (stall),
        .stall_dly   (stall_dly),
        .rst_pipe    (rst_pipe),
        .cnt_clr     (cnt_clr),
        .sel_ex      (sel_ex),
        .stall_ld    (stall_ld),
        .stall_ld_ex (stall_ld_ex),
        .stall_cnt   (stall_cnt)
    );

    typedef struct {
        int          cyc;
        string       nm;
        logic [3:0]  what;
        logic        sl;
        logic [7:0]  sel;
        logic        slex;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input string fld, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s.%s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, fld, got, want, cyc);
        end
    endtask

    // Monitor: the DUT presents outputs every cycle; compare whatever is due now.
    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s: expectation for cycle %0d never compared (now %0d)", q[i].nm, q[i].cyc, cyc);
                q.delete(i);
            end else if (q[i].cyc == cyc) begin
                if (q[i].what[0]) chk(q[i].nm, "stall_ld",    16'(stall_ld),    16'(q[i].sl));
                if (q[i].what[1]) chk(q[i].nm, "sel_ex",      16'(sel_ex),      16'(q[i].sel));
                if (q[i].what[2]) chk(q[i].nm, "stall_ld_ex", 16'(stall_ld_ex), 16'(q[i].slex));
                if (q[i].what[3]) chk(q[i].nm, "stall_cnt",   stall_cnt,        q[i].cnt);
                q.delete(i);
            end
        end
    end

    task automatic expect_at(input int dc, input string nm, input logic [3:0] what, input logic sl,
                             input logic [7:0] sel, input logic slex, input logic [15:0] cnt);
        exp_t e;
        e.cyc  = cyc + dc;
        e.nm   = nm;
        e.what = what;
        e.sl   = sl;
        e.sel  = sel;
        e.slex = slex;
        e.cnt  = cnt;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        src_adr    = '0;
        src_vld    = '0;
        stg_rd_adr = '0;
        stg_wbk    = '0;
        stg_rdy    = '0;
        stg_stall  = '0;
        stall      = 1'b0;
        stall_dly  = 1'b0;
        rst_pipe   = 1'b0;
        cnt_clr    = 1'b0;
    endtask

    task automatic set_src(input int s, input logic [4:0] a, input logic v);
        src_adr[s*AW +: AW] = a;
        src_vld[s]          = v;
    endtask

    task automatic set_stg(input int k, input logic [4:0] rd, input logic w, input logic r);
        stg_rd_adr[k*AW +: AW] = rd;
        stg_wbk[k]             = w;
        stg_rdy[k]             = r;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        expect_at(0, "reset", W_SL | W_SEL | W_SLEX | W_CNT, 1'b0, 8'h00, 1'b0, 16'd0);

        step(); rst = 1'b0;
        // EX-stage bypass, result ready
        idle(); set_src(0, 5'd5, 1'b1); set_stg(0, 5'd5, 1'b1, 1'b1);
        expect_at(0, "fwd_ex", W_SL, 1'b0, 8'h00, 1'b0, 16'd0);
        expect_at(1, "fwd_ex", W_SEL | W_SLEX, 1'b0, 8'b1000_0001, 1'b0, 16'd0);

        step(); // load-use in EX
        idle(); set_src(0, 5'd5, 1'b1); set_stg(0, 5'd5, 1'b1, 1'b0);
        expect_at(0, "load_use", W_SL | W_CNT, 1'b1, 8'h00, 1'b0, 16'd0);
        expect_at(1, "load_use", W_SEL | W_SLEX, 1'b0, 8'b1000_0001, 1'b1, 16'd0);

        step(); // load moved to MA and ready, bubble in EX
        idle(); set_src(0, 5'd5, 1'b1); set_stg(1, 5'd5, 1'b1, 1'b1);
        expect_at(0, "load_ma", W_SL | W_CNT, 1'b0, 8'h00, 1'b0, 16'd1);
        expect_at(1, "load_ma", W_SEL | W_SLEX, 1'b0, 8'b1000_0010, 1'b0, 16'd0);

        step(); // same rd in MA and WB: youngest wins
        idle(); set_src(1, 5'd7, 1'b1); set_stg(1, 5'd7, 1'b1, 1'b1); set_stg(2, 5'd7, 1'b1, 1'b1);
        expect_at(0, "youngest", W_SL, 1'b0, 8'h00, 1'b0, 16'd0);
        expect_at(1, "youngest", W_SEL | W_SLEX, 1'b0, 8'b0010_1000, 1'b0, 16'd0);

        step(); // x0 never forwarded; unread source ignored
        idle(); set_src(0, 5'd0, 1'b1); set_stg(0, 5'd0, 1'b1, 1'b1);
        set_src(1, 5'd9, 1'b0); set_stg(1, 5'd9, 1'b1, 1'b0);
        expect_at(0, "x0_novld", W_SL, 1'b0, 8'h00, 1'b0, 16'd0);
        expect_at(1, "x0_novld", W_SEL | W_SLEX, 1'b0, 8'b1000_1000, 1'b0, 16'd0);

        step(); // youngest not ready: no fallback to ready WB copy
        idle(); set_src(0, 5'd6, 1'b1); set_stg(1, 5'd6, 1'b1, 1'b0); set_stg(2, 5'd6, 1'b1, 1'b1);
        expect_at(0, "no_fallback", W_SL | W_CNT, 1'b1, 8'h00, 1'b0, 16'd1);
        expect_at(1, "no_fallback", W_SEL | W_SLEX, 1'b0, 8'b1000_0010, 1'b1, 16'd0);

        step(); // stalled MA stage is not a producer
        idle(); set_src(0, 5'd6, 1'b1); set_stg(1, 5'd6, 1'b1, 1'b0); stg_stall[1] = 1'b1;
        set_stg(2, 5'd6, 1'b1, 1'b1);
        expect_at(0, "stg_stall", W_SL | W_CNT, 1'b0, 8'h00, 1'b0, 16'd2);
        expect_at(1, "stg_stall", W_SEL | W_SLEX, 1'b0, 8'b1000_0100, 1'b0, 16'd0);

        step(); // load-use in EX, then bubble guard in the following cycle
        idle(); set_src(0, 5'd5, 1'b1); set_stg(0, 5'd5, 1'b1, 1'b0);
        expect_at(0, "guard_a", W_SL, 1'b1, 8'h00, 1'b0, 16'd0);
        expect_at(1, "guard_a", W_SLEX, 1'b0, 8'h00, 1'b1, 16'd0);
        step();
        expect_at(0, "guard_b", W_SL | W_CNT, 1'b0, 8'h00, 1'b0, 16'd3);
        expect_at(1, "guard_b", W_SEL | W_SLEX, 1'b0, 8'b1000_1000, 1'b0, 16'd0);

        step(); // hazard, then held through a global stall while stall_pre drops
        idle(); set_src(0, 5'd5, 1'b1); set_stg(1, 5'd5, 1'b1, 1'b0);
        expect_at(0, "keep_set", W_SL, 1'b1, 8'h00, 1'b0, 16'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            idle(); stall = 1'b1; stall_dly = 1'b1;
            expect_at(0, "keep_hold", W_SL, 1'b1, 8'h00, 1'b0, 16'd0);
            if (i == 0) expect_at(0, "keep_sel", W_SEL | W_SLEX, 1'b0, 8'b1000_0010, 1'b1, 16'd0);
        end
        step(); // flush while still stalled
        idle(); stall = 1'b1; stall_dly = 1'b1; rst_pipe = 1'b1;
        expect_at(0, "flush_pre", W_SL, 1'b1, 8'h00, 1'b0, 16'd0);
        step();
        idle(); stall = 1'b1; stall_dly = 1'b1;
        expect_at(0, "flush", W_SL | W_SEL | W_SLEX | W_CNT, 1'b0, 8'h00, 1'b0, 16'd8);

        step(); // flush plus counter clear
        idle(); rst_pipe = 1'b1; cnt_clr = 1'b1;
        step();
        idle(); set_src(0, 5'd5, 1'b1); set_stg(1, 5'd5, 1'b1, 1'b0);
        expect_at(0, "flush_clr", W_SL | W_SEL | W_SLEX | W_CNT, 1'b1, 8'h00, 1'b0, 16'd0);

        // Continuous hazard until the counter saturates
        for (int n = 1; n <= 65537; n++) begin
            step();
            if (n == 200)   expect_at(0, "cnt_200",  W_CNT, 1'b0, 8'h00, 1'b0, 16'd200);
            if (n == 65534) expect_at(0, "cnt_pre",  W_CNT, 1'b0, 8'h00, 1'b0, 16'hFFFE);
            if (n == 65535) expect_at(0, "cnt_max",  W_CNT, 1'b0, 8'h00, 1'b0, 16'hFFFF);
            if (n == 65537) expect_at(0, "cnt_sat",  W_SL | W_CNT, 1'b1, 8'h00, 1'b0, 16'hFFFF);
        end
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        expect_at(0, "cnt_clr", W_SL | W_CNT, 1'b1, 8'h00, 1'b0, 16'd0);

        step(); // asynchronous reset mid-hazard, checked before the next edge
        #2 rst = 1'b1;
        expect_at(0, "async_rst", W_SL | W_SEL | W_SLEX | W_CNT, 1'b1, 8'h00, 1'b0, 16'd0);
        step();
        rst = 1'b0;
        idle();
        step();
        step();

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
